crp16_mem_port_arbiter: RTL and testbench
=========================================

# crp16_mem_port_arbiter

Shares port B of the CRP16 asynchronous dual-port RAM between the datapath's EX/MEM load/store access and a host burst engine (loader/debug DMA). The datapath has fixed priority. An optional fairness counter guarantees host progress. When the datapath loses the port it receives a stall, and it must hold its stage counter and pipeline registers for that cycle. Port A (instruction fetch) is untouched.

## Interface
- HOST_STARVE_LIMIT, 4: consecutive datapath-won cycles, while the host is waiting, after which the host is forced one beat (1..15).
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  datapath requests port B this cycle (EX/MEM load or store).
- cpu_we  in  1  datapath write enable.
- cpu_addr  in  16  datapath address.
- cpu_wdata  in  16  datapath store data.
- cpu_rdata  out  16  q_b routed to the datapath.
- cpu_stall  out  1  datapath request not served this cycle.
- host_start  in  1  start-burst pulse; sampled only while host_busy=0.
- host_we  in  1  burst direction, latched at start (1 = write).
- host_addr  in  16  burst start address, latched at start.
- host_len  in  8  beat count, latched at start; 0 means 256.
- host_wdata  in  16  current write beat; held until host_beat.
- host_busy  out  1  burst in progress.
- host_beat  out  1  a host beat uses the port this cycle.
- host_rdata  out  16  q_b; valid when host_beat=1 and the latched direction is read.
- host_done  out  1  one-cycle pulse after the final beat.
- address_b  out  16  RAM port B address.
- data_b  out  16  RAM port B write data.
- wren_b  out  1  RAM port B write enable.
- q_b  in  16  RAM port B read data (asynchronous).

## Operation
- Registers:
  - busy
  - addr_cnt[15:0]
  - beats_left[8:0]
  - we_r
  - starve_cnt[3:0]
  - done_r
- Burst FSM has two states:
  - IDLE (busy=0): host_start=1 latches addr_cnt←host_addr, we_r←host_we, beats_left←(host_len==0 ? 256 : host_len), and moves to BURST.
  - BURST (busy=1): host_start is ignored.
- starve_hit = `CRP16_MEM_ARB_FAIRNESS_EN` active && starve_cnt == HOST_STARVE_LIMIT.
- Each cycle, the port owner is decided combinationally:
  - host_beat = busy && (!cpu_req || starve_hit).
  - cpu_grant = cpu_req && !host_beat.
  - cpu_stall = cpu_req && host_beat.
- Port mux:
  - cpu_grant: address_b=cpu_addr, data_b=cpu_wdata, wren_b=cpu_we.
  - host_beat: address_b=addr_cnt, data_b=host_wdata, wren_b=we_r.
  - Neither: address_b=0, data_b=0, wren_b=0.
- cpu_rdata and host_rdata are both wired directly to q_b.
- On each host_beat:
  - addr_cnt increments mod 2^16 (0xFFFF wraps to 0x0000).
  - beats_left decrements.
  - starve_cnt clears to 0.
  - If beats_left==1: busy←0 and done_r←1 (the FSM returns to IDLE).
- starve_cnt:
  - Increments when busy && cpu_grant.
  - Holds at HOST_STARVE_LIMIT.
  - Clears whenever busy=0.
- done_r clears after one cycle. host_done = done_r.

## Timing
- Reset values:
  - host_busy=0, host_beat=0, host_done=0, cpu_stall=0.
  - wren_b=0, address_b=0, data_b=0.
  - All internal counters 0.
- Reset mid-burst aborts the burst: no host_done, and the next cycle is IDLE.
- Grant is zero-latency. RAM read data is valid in the same cycle as the grant/beat.
- Burst start: host_start in cycle N gives host_busy=1 in N+1. The first beat is possible in N+1.
- host_done is high in the cycle after the last beat; host_busy is 0 in that same cycle.
- A host_start in the host_done cycle is accepted.
- Uncontended bursts run back-to-back: a burst of L beats finishes in exactly L cycles after the start cycle.
- Worst-case datapath stall is 1 cycle per HOST_STARVE_LIMIT+1 cycles while a burst is active.
- With fairness compiled out, the datapath never stalls.

## Configuration
- `CRP16_MEM_ARB_FAIRNESS_EN`
  - Defined: the starvation counter and forced host beat are compiled in, as above.
  - Undefined: starve_hit is constant 0, starve_cnt is removed, the datapath has strict priority, cpu_stall is constant 0, and the host can starve indefinitely.

## Test plan
- Reset then idle: no requests -> wren_b=0, address_b=0, host_busy=0, cpu_stall=0 every cycle.
- Uncontended write burst: host_start with addr=0x0010, len=3, we=1, wdata 0xAAAA/0xBBBB/0xCCCC -> host_beat on 3 consecutive cycles at addresses 0x0010..0x0012, host_done pulses once, the RAM holds the data.
- Wrap and len=0: host_addr=0xFFFE, len=0, read -> 256 beats at 0xFFFE, 0xFFFF, 0x0000 … 0x00FD; host_done on the 257th cycle after start.
- Fairness (macro on, LIMIT=4): cpu_req held high through a 2-beat host read burst -> pattern of 4 cpu grants, 1 host beat with cpu_stall=1, 4 cpu grants, 1 host beat; then host_done.
- Fairness off: same stimulus -> cpu_stall never asserts, host_beat stays 0 until cpu_req drops, then the burst completes.
- Reset at beat 2 of a 5-beat burst -> host_busy=0 next cycle, no host_done, and a new host_start is accepted immediately.

Source files
------------

// File: rtl/crp16_mem_port_arbiter.sv
// Port-B arbiter for the CRP16 dual-port RAM: datapath load/store has priority, host bursts fill idle cycles.
// Define CRP16_MEM_ARB_FAIRNESS_EN to force one host beat after HOST_STARVE_LIMIT consecutive datapath wins.
module crp16_mem_port_arbiter #(
  parameter int HOST_STARVE_LIMIT = 4
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_cpu_req,
  input  logic        i_cpu_we,
  input  logic [15:0] i_cpu_addr,
  input  logic [15:0] i_cpu_wdata,
  output logic [15:0] o_cpu_rdata,
  output logic        o_cpu_stall,
  input  logic        i_host_start,
  input  logic        i_host_we,
  input  logic [15:0] i_host_addr,
  input  logic [7:0]  i_host_len,
  input  logic [15:0] i_host_wdata,
  output logic        o_host_busy,
  output logic        o_host_beat,
  output logic [15:0] o_host_rdata,
  output logic        o_host_done,
  output logic [15:0] o_address_b,
  output logic [15:0] o_data_b,
  output logic        o_wren_b,
  input  logic [15:0] i_q_b
);

  if (HOST_STARVE_LIMIT < 1 || HOST_STARVE_LIMIT > 15) begin : g_limit_check
    $error("HOST_STARVE_LIMIT must be in 1..15");
  end

  typedef enum logic {S_IDLE, S_BURST} state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_addr_cnt, w_addr_cnt_nxt;
  logic [8:0]  r_beats_left, w_beats_left_nxt;
  logic        r_we, w_we_nxt;
  logic        r_done, w_done_nxt;
  logic        w_busy;
  logic        w_starve_hit;
  logic        w_host_beat;
  logic        w_cpu_grant;

  assign w_busy      = (r_state == S_BURST);
  assign w_host_beat = w_busy && (!i_cpu_req || w_starve_hit);
  assign w_cpu_grant = i_cpu_req && !w_host_beat;

`ifdef CRP16_MEM_ARB_FAIRNESS_EN
  logic [3:0] r_starve_cnt;

  assign w_starve_hit = (r_starve_cnt == 4'(HOST_STARVE_LIMIT));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_starve_cnt <= 4'd0;
    end else if (!w_busy || w_host_beat) begin
      r_starve_cnt <= 4'd0;
    end else if (w_cpu_grant && !w_starve_hit) begin
      r_starve_cnt <= r_starve_cnt + 4'd1;
    end
  end
`else
  assign w_starve_hit = 1'b0;
`endif

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state      <= S_IDLE;
      r_addr_cnt   <= 16'd0;
      r_beats_left <= 9'd0;
      r_we         <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_addr_cnt   <= w_addr_cnt_nxt;
      r_beats_left <= w_beats_left_nxt;
      r_we         <= w_we_nxt;
      r_done       <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_addr_cnt_nxt   = r_addr_cnt;
    w_beats_left_nxt = r_beats_left;
    w_we_nxt         = r_we;
    w_done_nxt       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_host_start) begin
          w_state_nxt      = S_BURST;
          w_addr_cnt_nxt   = i_host_addr;
          w_we_nxt         = i_host_we;
          // A zero length encodes a full 256-beat burst.
          w_beats_left_nxt = (i_host_len == 8'd0) ? 9'd256 : {1'b0, i_host_len};
        end
      end
      S_BURST: begin
        if (w_host_beat) begin
          w_addr_cnt_nxt   = r_addr_cnt + 16'd1;
          w_beats_left_nxt = r_beats_left - 9'd1;
          if (r_beats_left == 9'd1) begin
            w_state_nxt = S_IDLE;
            w_done_nxt  = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_address_b = 16'd0;
    o_data_b    = 16'd0;
    o_wren_b    = 1'b0;
    if (w_cpu_grant) begin
      o_address_b = i_cpu_addr;
      o_data_b    = i_cpu_wdata;
      o_wren_b    = i_cpu_we;
    end else if (w_host_beat) begin
      o_address_b = r_addr_cnt;
      o_data_b    = i_host_wdata;
      o_wren_b    = r_we;
    end
  end

  assign o_cpu_stall  = i_cpu_req && w_host_beat;
  assign o_cpu_rdata  = i_q_b;
  assign o_host_rdata = i_q_b;
  assign o_host_busy  = w_busy;
  assign o_host_beat  = w_host_beat;
  assign o_host_done  = r_done;

endmodule

// File: tb/tb_crp16_mem_port_arbiter.sv
// Directed bench for crp16_mem_port_arbiter with an asynchronous-read RAM model on port B.
module tb_crp16_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        host_start, host_we;
  logic [15:0] host_addr;
  logic [7:0]  host_len;
  logic [15:0] host_wdata, host_rdata;
  logic        host_busy, host_beat, host_done;
  logic [15:0] address_b, data_b, q_b;
  logic        wren_b;

  logic        preload;
  logic [15:0] mem [0:65535];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  crp16_mem_port_arbiter #(.HOST_STARVE_LIMIT(4)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_addr(cpu_addr), .i_cpu_wdata(cpu_wdata),
    .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
    .i_host_start(host_start), .i_host_we(host_we), .i_host_addr(host_addr), .i_host_len(host_len),
    .i_host_wdata(host_wdata), .o_host_busy(host_busy), .o_host_beat(host_beat),
    .o_host_rdata(host_rdata), .o_host_done(host_done),
    .o_address_b(address_b), .o_data_b(data_b), .o_wren_b(wren_b), .i_q_b(q_b)
  );

  function automatic logic [15:0] pat(input logic [15:0] a);
    return a ^ 16'h5A5A;
  endfunction

  always @(posedge clk) begin
    if (preload) begin
      for (int a = 0; a < 65536; a++) mem[a] <= pat(16'(a));
    end else if (wren_b) begin
      mem[address_b] <= data_b;
    end
  end
  assign q_b = mem[address_b];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [15:0] a;
    logic [9:0]  fpat;
    int          hidx;

    rst = 1'b1; preload = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'd0; cpu_wdata = 16'd0;
    host_start = 1'b0; host_we = 1'b0; host_addr = 16'd0; host_len = 8'd0; host_wdata = 16'd0;
    next_cycle();
    preload = 1'b0;
    #1;
    chk("rst_busy", host_busy, 1'b0);
    chk("rst_done", host_done, 1'b0);
    chk("rst_beat", host_beat, 1'b0);
    chk("rst_wren", wren_b, 1'b0);
    chk("rst_addr", address_b, 16'h0000);
    chk("rst_data", data_b, 16'h0000);
    chk("rst_stall", cpu_stall, 1'b0);
    next_cycle();
    rst = 1'b0;

    // idle: nothing requested
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      #1;
      chk("idle_wren", wren_b, 1'b0);
      chk("idle_addr", address_b, 16'h0000);
      chk("idle_busy", host_busy, 1'b0);
      chk("idle_stall", cpu_stall, 1'b0);
    end

    // len=0 read burst from 0xFFFE wraps through 0x0000
    next_cycle();
    host_start = 1'b1; host_addr = 16'hFFFE; host_len = 8'd0; host_we = 1'b0;
    #1;
    chk("wrap_start_busy", host_busy, 1'b0);
    chk("wrap_start_beat", host_beat, 1'b0);
    next_cycle();
    host_start = 1'b0;
    for (int i = 0; i < 256; i++) begin
      if (i > 0) next_cycle();
      #1;
      a = 16'hFFFE + 16'(i);
      chk("wrap_beat", host_beat, 1'b1);
      chk("wrap_busy", host_busy, 1'b1);
      chk("wrap_addr", address_b, a);
      chk("wrap_wren", wren_b, 1'b0);
      chk("wrap_rdata", host_rdata, pat(a));
      chk("wrap_done_early", host_done, 1'b0);
    end
    next_cycle();
    #1;
    chk("wrap_done", host_done, 1'b1);
    chk("wrap_end_busy", host_busy, 1'b0);
    chk("wrap_end_beat", host_beat, 1'b0);

    // uncontended 3-beat write burst at 0x0010, started in the done cycle
    host_start = 1'b1; host_addr = 16'h0010; host_len = 8'd3; host_we = 1'b1; host_wdata = 16'hAAAA;
    #1;
    chk("wr_start_beat", host_beat, 1'b0);
    next_cycle();
    host_start = 1'b0;
    #1;
    chk("wr_b0_beat", host_beat, 1'b1);
    chk("wr_b0_addr", address_b, 16'h0010);
    chk("wr_b0_data", data_b, 16'hAAAA);
    chk("wr_b0_wren", wren_b, 1'b1);
    chk("wr_b0_done", host_done, 1'b0);
    next_cycle();
    host_wdata = 16'hBBBB;
    #1;
    chk("wr_b1_addr", address_b, 16'h0011);
    chk("wr_b1_data", data_b, 16'hBBBB);
    next_cycle();
    host_wdata = 16'hCCCC;
    #1;
    chk("wr_b2_addr", address_b, 16'h0012);
    chk("wr_b2_data", data_b, 16'hCCCC);
    chk("wr_b2_wren", wren_b, 1'b1);
    next_cycle();
    #1;
    chk("wr_done", host_done, 1'b1);
    chk("wr_end_busy", host_busy, 1'b0);
    chk("wr_end_wren", wren_b, 1'b0);

    // datapath reads the burst data back
    next_cycle();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0010;
    #1;
    chk("rb0_rdata", cpu_rdata, 16'hAAAA);
    chk("rb0_stall", cpu_stall, 1'b0);
    chk("rb0_done", host_done, 1'b0);
    chk("rb0_wren", wren_b, 1'b0);
    next_cycle();
    cpu_addr = 16'h0011;
    #1;
    chk("rb1_rdata", cpu_rdata, 16'hBBBB);
    next_cycle();
    cpu_addr = 16'h0012;
    #1;
    chk("rb2_rdata", cpu_rdata, 16'hCCCC);
    chk("rb2_addr", address_b, 16'h0012);

    // contention: cpu_req held high through a 2-beat host read at 0x0040
    next_cycle();
    cpu_addr = 16'h0100;
    host_start = 1'b1; host_addr = 16'h0040; host_len = 8'd2; host_we = 1'b0;
    #1;
    chk("ct_start_addr", address_b, 16'h0100);
    chk("ct_start_stall", cpu_stall, 1'b0);
    next_cycle();
    host_start = 1'b0;
`ifdef CRP16_MEM_ARB_FAIRNESS_EN
    fpat = 10'b10000_10000;
    hidx = 0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) next_cycle();
      #1;
      chk("fair_beat", host_beat, fpat[i]);
      chk("fair_stall", cpu_stall, fpat[i]);
      if (fpat[i]) begin
        chk("fair_haddr", address_b, 16'h0040 + 16'(hidx));
        chk("fair_hrdata", host_rdata, pat(16'h0040 + 16'(hidx)));
        hidx++;
      end else begin
        chk("fair_caddr", address_b, 16'h0100);
        chk("fair_crdata", cpu_rdata, pat(16'h0100));
      end
    end
    next_cycle();
    #1;
    chk("fair_done", host_done, 1'b1);
    chk("fair_end_busy", host_busy, 1'b0);
    chk("fair_end_addr", address_b, 16'h0100);
`else
    fpat = 10'd0;
    hidx = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) next_cycle();
      #1;
      chk("strict_beat", host_beat, fpat[0]);
      chk("strict_stall", cpu_stall, 1'b0);
      chk("strict_busy", host_busy, 1'b1);
      chk("strict_addr", address_b, 16'h0100);
    end
    next_cycle();
    cpu_req = 1'b0;
    #1;
    chk("strict_b0_beat", host_beat, 1'b1);
    chk("strict_b0_addr", address_b, 16'h0040 + 16'(hidx));
    chk("strict_b0_rdata", host_rdata, pat(16'h0040));
    next_cycle();
    #1;
    chk("strict_b1_addr", address_b, 16'h0041);
    chk("strict_b1_beat", host_beat, 1'b1);
    next_cycle();
    #1;
    chk("strict_done", host_done, 1'b1);
    chk("strict_end_busy", host_busy, 1'b0);
`endif
    next_cycle();
    cpu_req = 1'b0;
    #1;
    chk("ct_done_clear", host_done, 1'b0);

    // reset during beat 2 of a 5-beat burst aborts it
    next_cycle();
    host_start = 1'b1; host_addr = 16'h0200; host_len = 8'd5; host_we = 1'b0;
    #1;
    next_cycle();
    host_start = 1'b0;
    #1;
    chk("ab_b0_addr", address_b, 16'h0200);
    next_cycle();
    rst = 1'b1;
    #1;
    chk("ab_b1_beat", host_beat, 1'b1);
    chk("ab_b1_addr", address_b, 16'h0201);
    next_cycle();
    rst = 1'b0;
    host_start = 1'b1; host_addr = 16'h0300; host_len = 8'd1;
    #1;
    chk("ab_busy", host_busy, 1'b0);
    chk("ab_done", host_done, 1'b0);
    chk("ab_beat", host_beat, 1'b0);
    next_cycle();
    host_start = 1'b0;
    #1;
    chk("ab_new_busy", host_busy, 1'b1);
    chk("ab_new_addr", address_b, 16'h0300);
    chk("ab_new_done", host_done, 1'b0);
    next_cycle();
    #1;
    chk("ab_new_fin", host_done, 1'b1);
    chk("ab_new_idle", host_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
